// File: rtl/m_ext_div_iterative.sv
`default_nettype none
// ============================================================================
// Module   : m_ext_div_iterative
// Function : Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient
//            bit per cycle, start/done handshake with a held result.
// Revision : 1.0 - initial release
// ============================================================================
module m_ext_div_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic [1:0]       div_opcode,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic [WIDTH-1:0] result_divide,
    output logic             done,
    output logic             busy
);

    localparam int                 c_cnt_w      = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_count_init = c_cnt_w'(WIDTH);
    localparam logic [WIDTH-1:0]   c_int_min    = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [c_cnt_w-1:0] counter_q, counter_d;
    logic [WIDTH-1:0]   rem_q,     rem_d;
    logic [WIDTH-1:0]   quo_q,     quo_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [1:0]         op_q,      op_d;
    logic               q_neg_q,   q_neg_d;
    logic               r_neg_q,   r_neg_d;
    logic [WIDTH-1:0]   result_q,  result_d;

    logic             w_signed;
    logic             w_sign1;
    logic             w_sign2;
    logic [WIDTH-1:0] w_abs1;
    logic [WIDTH-1:0] w_abs2;
    logic             w_div_zero;
    logic             w_overflow;
    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH-1:0] w_rem_sub;
    logic             w_fit;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_quo_res;
    logic [WIDTH-1:0] w_rem_res;

    // Operand preparation at accept time (raw operands drive the special cases)
    assign w_signed   = ~div_opcode[0];
    assign w_sign1    = w_signed & operand1[WIDTH-1];
    assign w_sign2    = w_signed & operand2[WIDTH-1];
    assign w_abs1     = w_sign1 ? (~operand1 + 1'b1) : operand1;
    assign w_abs2     = w_sign2 ? (~operand2 + 1'b1) : operand2;
    assign w_div_zero = (operand2 == '0);
    assign w_overflow = w_signed && (operand1 == c_int_min) && (operand2 == '1);

    // The shifted partial remainder needs WIDTH+1 bits; after a successful
    // subtract it is below the divisor, so the low WIDTH bits are exact.
    assign w_rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign w_fit       = (w_rem_shift >= {1'b0, divisor_q});
    assign w_rem_sub   = w_rem_shift[WIDTH-1:0] - divisor_q;
    assign w_rem_next  = w_fit ? w_rem_sub : w_rem_shift[WIDTH-1:0];
    assign w_quo_next  = {quo_q[WIDTH-2:0], w_fit};

    assign w_quo_res = (~op_q[0] & q_neg_q) ? (~w_quo_next + 1'b1) : w_quo_next;
    assign w_rem_res = (~op_q[0] & r_neg_q) ? (~w_rem_next + 1'b1) : w_rem_next;

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        op_d      = op_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        result_d  = result_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (startE) begin
                    op_d      = div_opcode;
                    q_neg_d   = w_sign1 ^ w_sign2;
                    r_neg_d   = w_sign1;
                    rem_d     = '0;
                    quo_d     = w_abs1;
                    divisor_d = w_abs2;
                    if (w_div_zero) begin
                        result_d = div_opcode[1] ? operand1 : '1;
                        state_d  = S_DONE;
                    end else if (w_overflow) begin
                        result_d = div_opcode[1] ? '0 : c_int_min;
                        state_d  = S_DONE;
                    end else begin
                        counter_d = c_count_init;
                        state_d   = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d     = w_rem_next;
                quo_d     = w_quo_next;
                counter_d = counter_q - 1'b1;
                if (counter_q == c_cnt_w'(1)) begin
                    result_d = op_q[1] ? w_rem_res : w_quo_res;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            counter_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            op_q      <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            op_q      <= op_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            result_q  <= result_d;
        end
    end

    assign result_divide = result_q;
    assign done          = (state_q == S_DONE);
    assign busy          = (state_q == S_CALC);

endmodule
`default_nettype wire
